// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the 16-lane vector/scalar memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (r0 wins).
module mem_arbiter #(
   parameter int ADDR_W = 13,
   parameter int LANES  = 16,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     r0_req,
   input  logic                     r0_we,
   input  logic                     r0_vec,
   input  logic [ADDR_W-1:0]        r0_addr,
   input  logic [LANES*DATA_W-1:0]  r0_wdata,
   input  logic                     r1_req,
   input  logic                     r1_we,
   input  logic                     r1_vec,
   input  logic [ADDR_W-1:0]        r1_addr,
   input  logic [LANES*DATA_W-1:0]  r1_wdata,
   output logic                     r0_gnt,
   output logic                     r1_gnt,
   output logic                     r0_rvalid,
   output logic                     r1_rvalid,
   output logic [LANES*DATA_W-1:0]  rdata,
   output logic [ADDR_W-1:0]        mem_address,
   output logic [LANES*DATA_W-1:0]  mem_data,
   output logic                     mem_wren,
   output logic                     mem_vec_scalar,
   input  logic [LANES*DATA_W-1:0]  mem_q,
   output logic                     busy,
   output logic [1:0]               dbg_state
);
   localparam int DW    = LANES * DATA_W;
   localparam int MW    = 16;
   localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state, state_nxt;
   logic                load;
   logic                pick;
   logic                owner;
   logic                cmd_we;
   logic                cmd_vec;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DW-1:0]       cmd_wdata;
   logic [CNT_W-1:0]    wait_cnt;
   logic                sel_vec;
   logic [DW-1:0]       sel_wdata;
   logic [DW-1:0]       cap_data;
   logic                unused_q_hi;

   // Handshake: rN_req is a valid held until rN_gnt; rN_gnt is a one-cycle ready pulse
   // raised only in ISSUE, and the requester drops or replaces req on the edge ending it.
`ifdef MEM_ARB_RR_EN
   logic last_gnt;
   assign pick = (r0_req && r1_req) ? ~last_gnt : r1_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last_gnt <= 1'b1;
      else if (load)
         last_gnt <= pick;
   end
`else
   assign pick = ~r0_req;
`endif

   assign sel_vec   = pick ? r1_vec : r0_vec;
   assign sel_wdata = pick ? r1_wdata : r0_wdata;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (r0_req || r1_req) begin
               load      = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = cmd_we ? IDLE : WAIT;
         WAIT:    if (wait_cnt == CNT_W'(1)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory keeps 16 bits per lane: zero-extend, and a scalar read returns lane 0 only.
   always_comb begin
      cap_data    = '0;
      unused_q_hi = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (cmd_vec || i == 0)
            cap_data[i*DATA_W +: DATA_W] = DATA_W'(mem_q[i*DATA_W +: MW]);
         unused_q_hi = unused_q_hi ^ (^mem_q[i*DATA_W+MW +: DATA_W-MW]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_vec   <= 1'b1;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         wait_cnt  <= '0;
         rdata     <= '0;
      end else begin
         if (load) begin
            owner    <= pick;
            cmd_we   <= pick ? r1_we : r0_we;
            cmd_vec  <= sel_vec;
            cmd_addr <= pick ? r1_addr : r0_addr;
            // Scalar lane 0 is fanned out so the memory's scalar path sees it on any lane.
            cmd_wdata <= sel_vec ? sel_wdata : {LANES{sel_wdata[DATA_W-1:0]}};
         end
         if (state == ISSUE && !cmd_we)
            wait_cnt <= CNT_W'(RD_LAT);
         else if (state == WAIT)
            wait_cnt <= wait_cnt - CNT_W'(1);
         if (state == WAIT && wait_cnt == CNT_W'(1))
            rdata <= cap_data;
      end
   end

   assign r0_gnt         = (state == ISSUE) && !owner;
   assign r1_gnt         = (state == ISSUE) &&  owner;
   assign r0_rvalid      = (state == DONE)  && !owner;
   assign r1_rvalid      = (state == DONE)  &&  owner;
   assign mem_wren       = (state == ISSUE) && cmd_we;
   assign mem_address    = cmd_addr;
   assign mem_data       = cmd_wdata;
   assign mem_vec_scalar = cmd_vec;
   assign busy           = (state != IDLE);
   assign dbg_state      = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-schedule model, behavioural memory,
// directed request sequences and a few literal expectations.
module tb_mem_arbiter;
   localparam int ADDR_W = 13;
   localparam int LANES  = 16;
   localparam int DATA_W = 32;
   localparam int RD_LAT = 1;
   localparam int DW     = LANES * DATA_W;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              r0_req = 1'b0, r0_we = 1'b0, r0_vec = 1'b0;
   logic              r1_req = 1'b0, r1_we = 1'b0, r1_vec = 1'b0;
   logic [ADDR_W-1:0] r0_addr = '0, r1_addr = '0;
   logic [DW-1:0]     r0_wdata = '0, r1_wdata = '0;
   logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
   logic [DW-1:0]     rdata, mem_data, mem_q;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_wren, mem_vec_scalar, busy;
   logic [1:0]        dbg_state_unused;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   mem_arbiter #(.ADDR_W(ADDR_W), .LANES(LANES), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_vec(r0_vec), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_vec(r1_vec), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
      .mem_vec_scalar(mem_vec_scalar), .mem_q(mem_q), .busy(busy), .dbg_state(dbg_state_unused)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input int a);
      return 16'(a * 7 + 3);
   endfunction

   // ---------------- behavioural memory (environment) ----------------
   bit [15:0] ram [DEPTH];
   bit        ram_wr [DEPTH];

   function automatic logic [DW-1:0] dev_read(input logic [ADDR_W-1:0] a);
      logic [DW-1:0] r;
      logic [ADDR_W-1:0] ai;
      for (int i = 0; i < LANES; i++) begin
         ai = ADDR_W'(a + ADDR_W'(i));
         r[i*DATA_W +: DATA_W] = {16'hDEAD, ram_wr[ai] ? ram[ai] : init_val(int'(ai))};
      end
      return r;
   endfunction

   always @(posedge clk) begin
      mem_q <= dev_read(mem_address);
      if (mem_wren) begin
         if (mem_vec_scalar) begin
            for (int i = 0; i < LANES; i++) begin
               ram[ADDR_W'(mem_address + ADDR_W'(i))]    <= mem_data[i*DATA_W +: 16];
               ram_wr[ADDR_W'(mem_address + ADDR_W'(i))] <= 1'b1;
            end
         end else begin
            ram[mem_address]    <= mem_data[15*DATA_W +: 16];
            ram_wr[mem_address] <= 1'b1;
         end
      end
   end

   // ---------------- transaction-schedule model ----------------
   bit [15:0] mmem [DEPTH];
   bit        mmem_wr [DEPTH];

   function automatic logic [15:0] mget(input int a);
      return mmem_wr[a] ? mmem[a] : init_val(a);
   endfunction

   function automatic logic [DW-1:0] norm_data(input logic vec, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++)
         r[i*DATA_W +: DATA_W] = vec ? d[i*DATA_W +: DATA_W] : d[DATA_W-1:0];
      return r;
   endfunction

   function automatic logic [DW-1:0] read_model(input logic vec, input logic [ADDR_W-1:0] a);
      logic [DW-1:0] r = '0;
      for (int i = 0; i < LANES; i++)
         if (vec || i == 0)
            r[i*DATA_W +: DATA_W] = {16'h0, mget(int'(ADDR_W'(a + ADDR_W'(i))))};
      return r;
   endfunction

   int                t_issue = -100, t_end = -100, t_rv = -100, m_owner = 0, m_last = 1;
   logic [DW-1:0]     m_rd = '0, exp_rdata = '0;
   logic [ADDR_W-1:0] cur_addr = '0, prev_addr = '0;
   logic              cur_vec = 1'b1, prev_vec = 1'b1, cur_chk = 1'b1, prev_chk = 1'b1, m_we = 1'b0;
   logic [DW-1:0]     cur_data = '0, prev_data = '0;

   always @(negedge clk) begin
      logic e_cur, w, nwe, nvec;
      logic [ADDR_W-1:0] naddr;
      logic [DW-1:0] nwd;
      if (!rst) begin
         t_issue = -100; t_end = -100; t_rv = -100; m_owner = 0; m_last = 1; m_we = 1'b0;
         exp_rdata = '0;
         cur_addr = '0; cur_vec = 1'b1; cur_data = '0; cur_chk = 1'b1;
         prev_addr = '0; prev_vec = 1'b1; prev_data = '0; prev_chk = 1'b1;
      end
      if (cyc == t_rv) exp_rdata = m_rd;
      e_cur = (cyc >= t_issue);
      check("r0_gnt", r0_gnt, cyc == t_issue && m_owner == 0);
      check("r1_gnt", r1_gnt, cyc == t_issue && m_owner == 1);
      check("r0_rvalid", r0_rvalid, cyc == t_rv && m_owner == 0);
      check("r1_rvalid", r1_rvalid, cyc == t_rv && m_owner == 1);
      check("mem_wren", mem_wren, cyc == t_issue && m_we);
      check("busy", busy, cyc >= t_issue && cyc <= t_end);
      check("rdata", rdata, exp_rdata);
      check("mem_address", mem_address, e_cur ? cur_addr : prev_addr);
      check("mem_vec_scalar", mem_vec_scalar, e_cur ? cur_vec : prev_vec);
      if (e_cur ? cur_chk : prev_chk)
         check("mem_data", mem_data, e_cur ? cur_data : prev_data);

      if (rst && cyc > t_end && (r0_req || r1_req)) begin
`ifdef MEM_ARB_RR_EN
         w = (r0_req && r1_req) ? (m_last == 0) : r1_req;
`else
         w = !r0_req;
`endif
         nwe   = w ? r1_we : r0_we;
         nvec  = w ? r1_vec : r0_vec;
         naddr = w ? r1_addr : r0_addr;
         nwd   = w ? r1_wdata : r0_wdata;
         prev_addr = cur_addr; prev_vec = cur_vec; prev_data = cur_data; prev_chk = cur_chk;
         cur_addr = naddr; cur_vec = nvec; cur_data = norm_data(nvec, nwd); cur_chk = nwe;
         m_owner = int'(w); m_last = int'(w); m_we = nwe; t_issue = cyc + 1;
         if (nwe) begin
            t_end = cyc + 1;
            t_rv  = -100;
            if (nvec) begin
               for (int i = 0; i < LANES; i++) begin
                  mmem[int'(ADDR_W'(naddr + ADDR_W'(i)))]    = nwd[i*DATA_W +: 16];
                  mmem_wr[int'(ADDR_W'(naddr + ADDR_W'(i)))] = 1'b1;
               end
            end else begin
               mmem[int'(naddr)]    = nwd[15:0];
               mmem_wr[int'(naddr)] = 1'b1;
            end
         end else begin
            t_end = cyc + 2 + RD_LAT;
            t_rv  = t_end;
            m_rd  = read_model(nvec, naddr);
         end
      end
   end

   // Event log for the literal expectations.
   int            rv0_cyc = 0, gnt1_cyc = 0, wren_cnt = 0, rv_cnt = 0;
   int            gnt_log[$];
   logic [DW-1:0] snap_data = '0;

   always @(negedge clk) begin
      if (r0_rvalid) rv0_cyc = cyc;
      if (r0_rvalid || r1_rvalid) rv_cnt++;
      if (r1_gnt) gnt1_cyc = cyc;
      if (r0_gnt) gnt_log.push_back(0);
      if (r1_gnt) gnt_log.push_back(1);
      if (mem_wren) wren_cnt++;
      if (mem_wren && r1_gnt) snap_data = mem_data;
   end

   // ---------------- drivers ----------------
   typedef struct {
      int                delay;
      logic              we;
      logic              vec;
      logic [ADDR_W-1:0] addr;
      logic [DW-1:0]     wdata;
   } cmd_t;

   cmd_t cq0[$], cq1[$];
   int   req_cyc0 = 0;

   function automatic cmd_t mk(input int d, input logic we, input logic vec,
                               input logic [ADDR_W-1:0] a, input logic [DW-1:0] wd);
      cmd_t c;
      c.delay = d; c.we = we; c.vec = vec; c.addr = a; c.wdata = wd;
      return c;
   endfunction

   task automatic drain(input int p);
      cmd_t c;
      bit   got;
      while ((p == 0) ? (cq0.size() > 0) : (cq1.size() > 0)) begin
         if (p == 0) c = cq0.pop_front(); else c = cq1.pop_front();
         repeat (c.delay) begin @(posedge clk); #1; end
         if (p == 0) begin
            r0_req = 1'b1; r0_we = c.we; r0_vec = c.vec; r0_addr = c.addr; r0_wdata = c.wdata;
            req_cyc0 = cyc;
         end else begin
            r1_req = 1'b1; r1_we = c.we; r1_vec = c.vec; r1_addr = c.addr; r1_wdata = c.wdata;
         end
         got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? r0_gnt : r1_gnt;
         end
         checks++;
         if (!got) begin
            failures++;
            $display("FAIL drv_gnt_timeout port=%0d act=no_gnt exp=gnt", p);
         end
         @(posedge clk); #1;
         if (p == 0) r0_req = 1'b0; else r1_req = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(posedge clk); #1;
         ok = (cyc > t_end + 1);
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL wait_idle act=busy exp=idle");
      end
   endtask

   function automatic logic [DW-1:0] vec_pattern(input logic [15:0] hi);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = {hi, 16'h1000 + 16'(i)};
      return r;
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      logic [DW-1:0] sc_wd;
      int w0, rv_before;

      // Reset with random inputs.
      repeat (4) begin
         @(posedge clk); #1;
         r0_req = 1'($urandom_range(0, 1)); r1_req = 1'($urandom_range(0, 1));
         r0_we = 1'($urandom_range(0, 1));  r1_we = 1'($urandom_range(0, 1));
         r0_vec = 1'($urandom_range(0, 1)); r1_vec = 1'($urandom_range(0, 1));
         r0_addr = ADDR_W'($urandom);       r1_addr = ADDR_W'($urandom);
         for (int j = 0; j < LANES; j++) begin
            r0_wdata[j*DATA_W +: DATA_W] = $urandom;
            r1_wdata[j*DATA_W +: DATA_W] = $urandom;
         end
      end
      r0_req = 1'b0; r1_req = 1'b0;
      rst = 1'b1;
      wait_idle();

      // r0 vector write then vector read.
      w0 = wren_cnt;
      cq0.push_back(mk(0, 1'b1, 1'b1, 13'h0100, vec_pattern(16'h5A5A)));
      drain(0);
      wait_idle();
      check("vec_wr_wren_cycles", wren_cnt - w0, 1);
      cq0.push_back(mk(0, 1'b0, 1'b1, 13'h0100, '0));
      drain(0);
      wait_idle();
      check("vec_rd_latency", rv0_cyc - req_cyc0, 3);
      check("vec_rd_data", rdata, vec_pattern(16'h0000));

      // r1 scalar write then scalar read.
      for (int i = 0; i < LANES; i++) sc_wd[i*DATA_W +: DATA_W] = 32'h1111_1111 * i;
      sc_wd[DATA_W-1:0] = 32'h0000_BEEF;
      cq1.push_back(mk(0, 1'b1, 1'b0, 13'h0005, sc_wd));
      drain(1);
      wait_idle();
      check("sc_wr_replicated", snap_data, {LANES{32'h0000_BEEF}});
      cq1.push_back(mk(0, 1'b0, 1'b0, 13'h0005, '0));
      drain(1);
      wait_idle();
      check("sc_rd_data", rdata, {{(DW-DATA_W){1'b0}}, 32'h0000_BEEF});

      // Simultaneous continuous reads.
      gnt_log.delete();
      cq0.push_back(mk(0, 1'b0, 1'b1, 13'h0100, '0));
      cq0.push_back(mk(0, 1'b0, 1'b1, 13'h0105, '0));
      cq1.push_back(mk(0, 1'b0, 1'b0, 13'h0005, '0));
      cq1.push_back(mk(0, 1'b0, 1'b1, 13'h0010, '0));
      fork
         drain(0);
         drain(1);
      join
      wait_idle();
      check("tie_gnt_count", gnt_log.size(), 4);
      if (gnt_log.size() == 4) begin
`ifdef MEM_ARB_RR_EN
         check("tie_gnt_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0101);
`else
         check("tie_gnt_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0], gnt_log[3][0]}, 4'b0011);
`endif
      end

      // Request during busy: r1 rises while r0's read is in WAIT.
      cq0.push_back(mk(0, 1'b0, 1'b1, 13'h0100, '0));
      cq1.push_back(mk(2, 1'b0, 1'b0, 13'h0005, '0));
      fork
         drain(0);
         drain(1);
      join
      wait_idle();
      check("busy_r1_gnt_after_done", gnt1_cyc - rv0_cyc, 2);

      // Reset in the middle of a read.
      rv_before = rv_cnt;
      cq0.push_back(mk(0, 1'b0, 1'b1, 13'h0100, '0));
      drain(0);
      rst = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      wait_idle();
      check("rst_mid_rd_no_rvalid", rv_cnt - rv_before, 0);
      check("rst_mid_rd_rdata", rdata, '0);
      check("rst_mid_rd_busy", busy, 1'b0);

      // Recovery read after reset.
      cq1.push_back(mk(0, 1'b0, 1'b1, 13'h0100, '0));
      drain(1);
      wait_idle();
      check("recover_rd_data", rdata, vec_pattern(16'h0000));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request arbiter and sequencer in front of the 16-lane vector/scalar memory controller. It accepts vector (16 × 16-bit lanes) or scalar memory requests from two requesters, typically the vector execution unit (r0) and the program/data loader (r1). It serialises them onto the single memory port, drives `wren` and `vec_scalar` with correct timing, and returns read data with a valid pulse after the memory read latency.

## Interface
- `ADDR_W`, 13, word address width (matches memory address).
- `LANES`, 16, vector lanes per access.
- `DATA_W`, 32, lane width on request and response buses; memory stores low 16 bits.
- `RD_LAT`, 1, memory read latency in cycles, ≥1.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `r0_req`, `r1_req`  in  1  request valid; held until `rN_gnt`.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read.
- `r0_vec`, `r1_vec`  in  1  1 = vector (16 lanes), 0 = scalar (lane 0).
- `r0_addr`, `r1_addr`  in  ADDR_W  base word address.
- `r0_wdata`, `r1_wdata`  in  LANES×DATA_W  write data.
- `r0_gnt`, `r1_gnt`  out  1  one-cycle acceptance pulse.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle read-data-valid pulse.
- `rdata`  out  LANES×DATA_W  read data, shared by both requesters.
- `mem_address`  out  ADDR_W  to memory `address`.
- `mem_data`  out  LANES×DATA_W  to memory `data`.
- `mem_wren`  out  1  to memory `wren`.
- `mem_vec_scalar`  out  1  to memory `vec_scalar`.
- `mem_q`  in  LANES×DATA_W  from memory `q`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE.** If either `req` is high, pick a winner (see Configuration) and latch its `we`, `vec`, `addr` and `wdata` into the command register. Record the owner, then go to ISSUE.
- **ISSUE.** One cycle.
  - `rOwner_gnt` = 1.
  - `mem_address`, `mem_vec_scalar` and `mem_data` are driven from the command register.
  - `mem_wren` = latched `we`.
  - A write goes to IDLE. A read goes to WAIT with the wait counter set to RD_LAT.
- **WAIT.** Counter decrements each cycle. On the cycle the counter equals 1, capture `mem_q` into `rdata`, then go to DONE.
- **DONE.** One cycle. `rOwner_rvalid` = 1, then go to IDLE.
- **Scalar write.** Latched lane 0 is replicated onto all `mem_data` lanes, so the memory's scalar lane-15 path writes the same value.
- **Scalar read.** `rdata` lane 0 = `mem_q` lane 0 [15:0] zero-extended; lanes 1..15 = 0.
- **Vector read.** Each lane = `mem_q` lane [15:0] zero-extended; upper 16 bits are always 0.
- **Addresses.** Passed unchanged. Lane wrap past 8191 is memory behaviour and is not checked here.
- **Outside ISSUE.** `mem_wren` = 0. `mem_address`, `mem_data` and `mem_vec_scalar` hold the command register value.
- **Requests while not IDLE.** Ignored. `gnt` is never issued outside ISSUE.
- **Requester rule.** Drop or replace `req` on the edge ending the `gnt` cycle.
- **`rdata` hold.** `rdata` holds its value until the next read capture.

## Timing
- Reset (async assert, sync release): FSM IDLE, command register 0, `mem_vec_scalar` 1, `mem_wren` 0, all `gnt`/`rvalid` 0, `rdata` 0, `busy` 0, round-robin pointer = r1 (so r0 wins the first tie).
- **Write.** `req` seen in cycle 0, ISSUE with `gnt` and `mem_wren` in cycle 1, IDLE in cycle 2. Peak throughput is 1 write per 2 cycles.
- **Read.** Accepted in cycle 0, ISSUE in cycle 1, WAIT in cycles 2..1+RD_LAT, `rvalid` in cycle 2+RD_LAT, IDLE in cycle 3+RD_LAT.
- **Reset mid-operation.** Any pending read is dropped and no `rvalid` is issued. A write in ISSUE is aborted because `mem_wren` drops asynchronously.
- **Simultaneous requests** are resolved in IDLE only. The loser keeps `req` asserted and is served next.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. On a tie, the requester not granted last wins. The pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, r0 always wins ties. There is no pointer register.

## Test plan
- **Reset values.** `rst`=0 with random inputs -> every output at its reset value, `mem_wren` 0, `busy` 0.
- **r0 vector write then read.** Vector write to addr 0x0100, lanes = 0x1000+i, then vector read of 0x0100 -> `mem_wren` high exactly 1 cycle; `r0_rvalid` in cycle 3 after request (RD_LAT=1); `rdata` lane i = 0x00001000+i.
- **r1 scalar write then read.** Scalar write of 0xBEEF to addr 0x0005 (lane 0), then scalar read -> all `mem_data` lanes = 0xBEEF during ISSUE; `rdata` lane 0 = 0x0000BEEF, other lanes 0.
- **Simultaneous reads.** Both requesters read continuously from cycle 0.
  - With `MEM_ARB_RR_EN`: grants alternate r0, r1, r0, r1.
  - Without it: r0 is granted until it drops `req`.
- **Request during busy.** r1 raises `req` while r0's read is in WAIT -> no `r1_gnt` before DONE; r1 is granted in the first IDLE cycle after DONE.
- **Reset mid-read.** `rst` asserted during WAIT, released 2 cycles later -> no `rvalid`; FSM IDLE; `rdata` = 0.
